axil_reg_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one AXI4-Lite master port to a generated register bank (word-addressed, 32-bit data).
- Each requester uses a simple req/ack bus. The arbiter serialises accesses and runs the AW/W/B or AR/R handshakes.
- Only one transaction is outstanding at a time.
- Sits between the control-plane sequencers (configuration loader, monitor poller) and the register bank.

---
 rtl/axil_reg_arbiter.sv | 168 ++++++++++++++++
 tb/tb_axil_reg_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_arbiter.sv
// Two-requester round-robin arbiter sharing one AXI4-Lite master port.
// One access is outstanding at a time; completion is a one-cycle ack pulse.
module axil_reg_arbiter #(
    parameter int unsigned ADDR_W = 3,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [63:0]           wdata,
    input  logic [7:0]            wstrb,
    output logic [1:0]            ack,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W+1:0]     awaddr,
    output logic [2:0]            awprot,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata_o,
    output logic [3:0]            wstrb_o,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W+1:0]     araddr,
    output logic [2:0]            arprot,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RRESP,
        ACK
    } state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic                grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic [1:0]          ack_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    // Winner of arbitration: on a tie, the requester not served last time.
    logic                pick_c;
    logic                aw_done_c;
    logic                w_done_c;

    assign pick_c    = req[1] & (~req[0] | ~last_grant_q);
    assign aw_done_c = ~awvalid_q | awready;
    assign w_done_c  = ~wvalid_q | wready;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q      <= pick_c;
                        last_grant_q <= pick_c;
                        addr_q       <= pick_c ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                        wdata_q      <= pick_c ? wdata[63:32] : wdata[31:0];
                        wstrb_q      <= pick_c ? wstrb[7:4] : wstrb[3:0];
                        if (we[pick_c]) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    // AW and W channels complete independently, possibly together.
                    if (awvalid_q && awready) awvalid_q <= 1'b0;
                    if (wvalid_q && wready)   wvalid_q  <= 1'b0;
                    if (aw_done_c && w_done_c) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        err_q          <= |bresp;
                        bready_q       <= 1'b0;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= ACK;
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RRESP;
                    end
                end
                RRESP: begin
                    if (rvalid) begin
                        rdata_q        <= rdata_i;
                        err_q          <= |rresp;
                        rready_q       <= 1'b0;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign awvalid = awvalid_q;
    assign awaddr  = {addr_q, 2'b00};
    assign awprot  = PROT;
    assign wvalid  = wvalid_q;
    assign wdata_o = wdata_q;
    assign wstrb_o = wstrb_q;
    assign bready  = bready_q;
    assign arvalid = arvalid_q;
    assign araddr  = {addr_q, 2'b00};
    assign arprot  = PROT;
    assign rready  = rready_q;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter with a configurable-latency AXI4-Lite slave.
module tb_axil_reg_arbiter;

    localparam int unsigned ADDR_W = 3;

    logic                aclk;
    logic                areset_n;
    logic [1:0]          req;
    logic [1:0]          we;
    logic [2*ADDR_W-1:0] addr;
    logic [63:0]         wdata;
    logic [7:0]          wstrb;
    logic [1:0]          ack;
    logic                err;
    logic [31:0]         rdata;
    logic                awvalid, awready, wvalid, wready, bvalid, bready;
    logic                arvalid, arready, rvalid, rready;
    logic [ADDR_W+1:0]   awaddr, araddr;
    logic [2:0]          awprot, arprot;
    logic [31:0]         wdata_o, rdata_i;
    logic [3:0]          wstrb_o;
    logic [1:0]          bresp, rresp;

    int n_asserts = 0;
    int n_fail    = 0;

    // Slave behaviour knobs
    int   aw_delay = 0, w_delay = 0, ar_delay = 0;
    int   aw_age = 0, w_age = 0, ar_age = 0, b_age = 0, r_age = 0;
    logic b_stall = 1'b0;

    axil_reg_arbiter #(.ADDR_W(ADDR_W), .PROT(3'b000)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ack(ack), .err(err), .rdata(rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata_i(rdata_i), .rresp(rresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Slave: ready after N cycles of valid; response one cycle after ready/bready rises.
    always @(posedge aclk) begin
        #1;
        aw_age  = awvalid ? aw_age + 1 : 0;
        awready = awvalid && (aw_age > aw_delay);
        w_age   = wvalid ? w_age + 1 : 0;
        wready  = wvalid && (w_age > w_delay);
        ar_age  = arvalid ? ar_age + 1 : 0;
        arready = arvalid && (ar_age > ar_delay);
        b_age   = bready ? b_age + 1 : 0;
        bvalid  = bready && (b_age >= 2) && !b_stall;
        r_age   = rready ? r_age + 1 : 0;
        rvalid  = rready && (r_age >= 2);
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int i, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output int lat, output logic [1:0] ack_o,
                       output logic err_o, output logic [31:0] rd_o);
        we[i] = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*32 +: 32] = d;
        wstrb[i*4 +: 4] = s;
        req[i] = 1'b1;
        lat = -1; ack_o = '0; err_o = 1'bx; rd_o = 'x;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (ack != 2'b00) begin
                lat = c; ack_o = ack; err_o = err; rd_o = rdata;
                break;
            end
        end
        tick();
        req[i] = 1'b0;
    endtask

    int          lat;
    logic [1:0]  ack_s;
    logic        err_s;
    logic [31:0] rd_s;

    initial begin
        int          n_ack, aw_c, w_c, br_c, overlap, acks, seen, gcnt;
        logic [1:0]  ackp;
        int          rem [2];
        logic        order [8];

        areset_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; wstrb = '0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 2'b00; rresp = 2'b00; rdata_i = 32'h0;
        repeat (3) tick();
        chk("reset_ctrl", 32'({awvalid, wvalid, bready, arvalid, rready, ack, err}), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("prot", 32'({awprot, arprot}), 32'h0);
        areset_n = 1'b1;
        tick();

        // Single write, zero-wait slave
        txn(0, 1'b1, 3'b101, 32'hDEADBEEF, 4'hF, lat, ack_s, err_s, rd_s);
        chk("wr_lat", 32'(lat), 32'd4);
        chk("wr_ack", 32'(ack_s), 32'h1);
        chk("wr_err", 32'(err_s), 32'h0);
        chk("wr_awaddr", 32'(awaddr), 32'h14);
        chk("wr_wdata", wdata_o, 32'hDEADBEEF);
        chk("wr_wstrb", 32'(wstrb_o), 32'hF);

        // Single read by requester 1
        rdata_i = 32'h0000000B;
        txn(1, 1'b0, 3'b100, 32'h0, 4'h0, lat, ack_s, err_s, rd_s);
        chk("rd_lat", 32'(lat), 32'd4);
        chk("rd_ack", 32'(ack_s), 32'h2);
        chk("rd_rdata", rd_s, 32'h0000000B);
        chk("rd_araddr", 32'(araddr), 32'h10);

        // Requester 0 served alone, then a fresh tie must go to requester 1
        txn(0, 1'b0, 3'b001, 32'h0, 4'h0, lat, ack_s, err_s, rd_s);
        chk("rr_solo_ack", 32'(ack_s), 32'h1);
        we = 2'b00; addr = {3'b010, 3'b011}; req = 2'b11;
        ack_s = '0;
        for (int c = 0; c < 50 && ack_s == 2'b00; c++) begin tick(); ack_s = ack; end
        chk("rr_tie_first", 32'(ack_s), 32'h2);
        tick(); req[1] = 1'b0;
        ack_s = '0;
        for (int c = 0; c < 50 && ack_s == 2'b00; c++) begin tick(); ack_s = ack; end
        chk("rr_tie_second", 32'(ack_s), 32'h1);
        tick(); req[0] = 1'b0;

        // Both held after reset: strict alternation starting with requester 0
        areset_n = 1'b0; tick(); tick(); areset_n = 1'b1; tick();
        we = 2'b00; addr = {3'b110, 3'b111};
        rem[0] = 4; rem[1] = 4; req = 2'b11; ackp = '0; gcnt = 0;
        for (int c = 0; c < 200 && (gcnt < 8 || req != 2'b00); c++) begin
            tick();
            if (ack[0] && gcnt < 8) begin order[gcnt] = 1'b0; gcnt++; rem[0]--; end
            if (ack[1] && gcnt < 8) begin order[gcnt] = 1'b1; gcnt++; rem[1]--; end
            for (int i = 0; i < 2; i++) begin
                if (ackp[i]) req[i] = 1'b0;
                else if (!req[i] && rem[i] > 0 && !ack[i]) req[i] = 1'b1;
            end
            ackp = ack;
        end
        req = 2'b00;
        chk("tie_count", 32'(gcnt), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("tie_order%0d", k), 32'(order[k]), 32'(k % 2));

        // Split AW/W: awready three cycles late, wready immediate
        tick();
        aw_delay = 3;
        we[0] = 1'b1; addr[2:0] = 3'b011; wdata[31:0] = 32'hA5A5A5A5; wstrb[3:0] = 4'h3;
        req[0] = 1'b1;
        aw_c = 0; w_c = 0; br_c = 0; overlap = 0; acks = 0; lat = -1; seen = 0;
        for (int c = 1; c <= 60 && seen < 4; c++) begin
            tick();
            if (awvalid) aw_c++;
            if (wvalid) w_c++;
            if (bready) br_c++;
            if (bready && (awvalid || wvalid)) overlap++;
            if (ack != 2'b00) begin acks++; if (lat < 0) lat = c; end
            if (lat >= 0) seen++;
            if (seen == 2) req[0] = 1'b0;
        end
        aw_delay = 0;
        chk("split_aw_cycles", 32'(aw_c), 32'd4);
        chk("split_w_cycles", 32'(w_c), 32'd1);
        chk("split_bready_cycles", 32'(br_c), 32'd2);
        chk("split_overlap", 32'(overlap), 32'd0);
        chk("split_acks", 32'(acks), 32'd1);
        chk("split_lat", 32'(lat), 32'd7);

        // Error responses and rdata retention across a write
        rresp = 2'b10; rdata_i = 32'h12345678;
        txn(1, 1'b0, 3'b010, 32'h0, 4'h0, lat, ack_s, err_s, rd_s);
        rresp = 2'b00; rdata_i = 32'hFFFF0000;
        chk("rerr_ack", 32'(ack_s), 32'h2);
        chk("rerr_err", 32'(err_s), 32'h1);
        chk("rerr_rdata", rd_s, 32'h12345678);
        txn(0, 1'b1, 3'b000, 32'h0BADF00D, 4'hF, lat, ack_s, err_s, rd_s);
        chk("wok_err", 32'(err_s), 32'h0);
        chk("wok_rdata_hold", rd_s, 32'h12345678);
        bresp = 2'b11;
        txn(1, 1'b1, 3'b111, 32'h1, 4'h1, lat, ack_s, err_s, rd_s);
        bresp = 2'b00;
        chk("werr_err", 32'(err_s), 32'h1);
        chk("werr_ack", 32'(ack_s), 32'h2);

        // Reset in the middle of a stalled write response
        b_stall = 1'b1;
        we[0] = 1'b1; addr[2:0] = 3'b001; wdata[31:0] = 32'h55; wstrb[3:0] = 4'hF;
        req[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin tick(); seen = int'(bready); end
        chk("mid_reach_wresp", 32'(seen), 32'd1);
        tick();
        areset_n = 1'b0;
        tick();
        chk("mid_rst1", 32'({awvalid, wvalid, bready, arvalid, rready, ack, err}), 32'h0);
        req[0] = 1'b0;
        tick();
        chk("mid_rst2", 32'({awvalid, wvalid, bready, arvalid, rready, ack, err}), 32'h0);
        areset_n = 1'b1; b_stall = 1'b0;
        n_ack = 0;
        repeat (5) begin tick(); if (ack != 2'b00) n_ack++; end
        chk("mid_no_ack", 32'(n_ack), 32'd0);
        txn(0, 1'b1, 3'b110, 32'hCAFEF00D, 4'hF, lat, ack_s, err_s, rd_s);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_ack", 32'(ack_s), 32'h1);
        chk("post_rst_wdata", wdata_o, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
